// File: rtl/spike_rate_bank.sv
// spike_rate_bank: multi-channel spike rate counter bank.
// Counts rising edges on NCH spike lines per window (window delimited by a
// one-cycle win_tick), latches all counts and saturation flags at each window
// boundary, and serves them as a flat bus plus an indexed registered readout.
// Optional macro SPIKE_SYNC_EN inserts a 2-flop synchroniser per spike line.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   spike_in[NCH]     raw spike lines
//   win_tick          window-boundary pulse
//   enable            1 = count, 0 = freeze counters and ignore win_tick
//   rd_sel            channel index for rd_data/rd_sat
//   rd_data, rd_sat   latched count/flag of channel rd_sel (1-cycle latency)
//   cnt_bus, sat_bus  all latched counts/flags
//   frame_valid       pulse the cycle after a latch
//   window_id         wrapping count of latched windows
module spike_rate_bank #(
  parameter int unsigned NCH  = 8,
  parameter int unsigned CW   = 16,
  parameter int unsigned SELW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    spike_in,
  input  logic              win_tick,
  input  logic              enable,
  input  logic [SELW-1:0]   rd_sel,
  output logic [CW-1:0]     rd_data,
  output logic              rd_sat,
  output logic [NCH*CW-1:0] cnt_bus,
  output logic [NCH-1:0]    sat_bus,
  output logic              frame_valid,
  output logic [15:0]       window_id
);

  localparam int unsigned WIDW = 16;
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [NCH-1:0]    s_c;
  logic [NCH-1:0]    edge_c;
  logic              latch_c;

  logic [NCH-1:0]    s_d_q, s_d_d;
  logic [CW-1:0]     cnt_q [NCH];
  logic [CW-1:0]     cnt_d [NCH];
  logic [NCH-1:0]    sat_q, sat_d;
  logic [NCH*CW-1:0] cnt_bus_q, cnt_bus_d;
  logic [NCH-1:0]    sat_bus_q, sat_bus_d;
  logic [CW-1:0]     rd_data_q, rd_data_d;
  logic              rd_sat_q, rd_sat_d;
  logic              fv_q, fv_d;
  logic [WIDW-1:0]   win_q, win_d;

`ifdef SPIKE_SYNC_EN
  // Two-flop synchroniser for spikes arriving from another clock domain.
  logic [NCH-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= spike_in;
      sync2_q <= sync1_q;
    end
  end

  assign s_c = sync2_q;
`else
  assign s_c = spike_in;
`endif

  assign edge_c  = s_c & ~s_d_q;
  assign latch_c = enable & win_tick;

  // Next-state: counting, saturation, window latch and readout mux.
  always_comb begin
    s_d_d     = s_c;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    cnt_bus_d = cnt_bus_q;
    sat_bus_d = sat_bus_q;
    win_d     = win_q;
    fv_d      = 1'b0;
    rd_data_d = '0;
    rd_sat_d  = 1'b0;

    if (enable) begin
      for (int i = 0; i < int'(NCH); i++) begin
        if (latch_c) begin
          cnt_bus_d[i*CW +: CW] = cnt_q[i];
          sat_bus_d[i]          = sat_q[i];
          // An edge coincident with the tick opens the new window.
          cnt_d[i]              = edge_c[i] ? CW'(1) : '0;
          sat_d[i]              = 1'b0;
        end else if (edge_c[i]) begin
          if (cnt_q[i] == CNT_MAX) sat_d[i] = 1'b1;
          else                     cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end

    if (latch_c) begin
      win_d = win_q + WIDW'(1);
      fv_d  = 1'b1;
    end

    // Out-of-range rd_sel matches no channel and reads 0.
    for (int i = 0; i < int'(NCH); i++) begin
      if (rd_sel == SELW'(i)) begin
        rd_data_d = cnt_bus_q[i*CW +: CW];
        rd_sat_d  = sat_bus_q[i];
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_d_q     <= '0;
      sat_q     <= '0;
      cnt_bus_q <= '0;
      sat_bus_q <= '0;
      rd_data_q <= '0;
      rd_sat_q  <= 1'b0;
      fv_q      <= 1'b0;
      win_q     <= '0;
      for (int i = 0; i < int'(NCH); i++) cnt_q[i] <= '0;
    end else begin
      s_d_q     <= s_d_d;
      sat_q     <= sat_d;
      cnt_bus_q <= cnt_bus_d;
      sat_bus_q <= sat_bus_d;
      rd_data_q <= rd_data_d;
      rd_sat_q  <= rd_sat_d;
      fv_q      <= fv_d;
      win_q     <= win_d;
      for (int i = 0; i < int'(NCH); i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_sat      = rd_sat_q;
  assign cnt_bus     = cnt_bus_q;
  assign sat_bus     = sat_bus_q;
  assign frame_valid = fv_q;
  assign window_id   = win_q;

endmodule

// File: tb/tb_spike_rate_bank.sv
// Directed bench for spike_rate_bank (NCH=6, CW=4, SELW=3).
module tb_spike_rate_bank;

  localparam int unsigned NCH  = 6;
  localparam int unsigned CW   = 4;
  localparam int unsigned SELW = 3;
`ifdef SPIKE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH-1:0]    spike_in;
  logic              win_tick;
  logic              enable;
  logic [SELW-1:0]   rd_sel;
  logic [CW-1:0]     rd_data;
  logic              rd_sat;
  logic [NCH*CW-1:0] cnt_bus;
  logic [NCH-1:0]    sat_bus;
  logic              frame_valid;
  logic [15:0]       window_id;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  spike_rate_bank #(.NCH(NCH), .CW(CW), .SELW(SELW)) dut (
    .clk        (clk),
    .reset      (reset),
    .spike_in   (spike_in),
    .win_tick   (win_tick),
    .enable     (enable),
    .rd_sel     (rd_sel),
    .rd_data    (rd_data),
    .rd_sat     (rd_sat),
    .cnt_bus    (cnt_bus),
    .sat_bus    (sat_bus),
    .frame_valid(frame_valid),
    .window_id  (window_id)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic pulse(input int ch, input int n);
    repeat (n) begin
      spike_in[ch] = 1'b1;
      step();
      spike_in[ch] = 1'b0;
      step();
    end
  endtask

  task automatic tick();
    win_tick = 1'b1;
    step();
    win_tick = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    spike_in = '0;
    win_tick = 1'b0;
    enable   = 1'b1;
    rd_sel   = '0;
    step();
    check("rst_bus",  32'(cnt_bus), 32'h0);
    check("rst_sat",  32'(sat_bus), 32'h0);
    check("rst_win",  32'(window_id), 32'h0);
    check("rst_fv",   32'(frame_valid), 32'h0);
    check("rst_rd",   32'(rd_data), 32'h0);
    reset = 1'b0;
    step();

    // Basic counting on ch0 and ch2.
    pulse(0, 5);
    pulse(2, 3);
    idle(3);
    check("fv_idle", 32'(frame_valid), 32'h0);
    tick();
    check("t1_fv",  32'(frame_valid), 32'h1);
    check("t1_bus", 32'(cnt_bus), 32'h000305);
    check("t1_win", 32'(window_id), 32'h1);
    rd_sel = 3'd2;
    step();
    check("t1_rd",    32'(rd_data), 32'h3);
    check("t1_fv_lo", 32'(frame_valid), 32'h0);
    rd_sel = 3'd0;
    step();
    check("t1_rd0", 32'(rd_data), 32'h5);
    rd_sel = 3'd7;
    step();
    check("t1_rd_oor", 32'(rd_data), 32'h0);

    // Saturation on ch1, then recovery in the next window.
    pulse(1, 20);
    idle(3);
    tick();
    check("t2_bus", 32'(cnt_bus), 32'h0000F0);
    check("t2_sat", 32'(sat_bus), 32'h02);
    check("t2_win", 32'(window_id), 32'h2);
    rd_sel = 3'd1;
    step();
    check("t2_rd",    32'(rd_data), 32'hF);
    check("t2_rdsat", 32'(rd_sat), 32'h1);
    pulse(1, 2);
    idle(3);
    tick();
    check("t2b_bus", 32'(cnt_bus), 32'h000020);
    check("t2b_sat", 32'(sat_bus), 32'h00);
    step();
    check("t2b_rdsat", 32'(rd_sat), 32'h0);

    // Edge coincident with tick belongs to the new window.
    pulse(3, 4);
    idle(3);
    spike_in[3] = 1'b1;
    repeat (LAT) step();
    tick();
    check("t3_bus", 32'(cnt_bus), 32'h004000);
    check("t3_win", 32'(window_id), 32'h4);
    spike_in[3] = 1'b0;
    idle(3);
    tick();
    check("t3b_bus", 32'(cnt_bus), 32'h001000);
    check("t3b_win", 32'(window_id), 32'h5);

    // Back-to-back ticks.
    win_tick = 1'b1;
    step();
    check("bb1_fv",  32'(frame_valid), 32'h1);
    check("bb1_bus", 32'(cnt_bus), 32'h0);
    step();
    check("bb2_fv",  32'(frame_valid), 32'h1);
    check("bb2_win", 32'(window_id), 32'h7);
    win_tick = 1'b0;
    step();
    check("bb3_fv", 32'(frame_valid), 32'h0);

    // Disabled window: pulses and ticks ignored.
    enable = 1'b0;
    pulse(0, 3);
    tick();
    check("dis_fv1", 32'(frame_valid), 32'h0);
    pulse(0, 3);
    tick();
    check("dis_fv2", 32'(frame_valid), 32'h0);
    check("dis_win", 32'(window_id), 32'h7);
    spike_in[4] = 1'b1;
    idle(3);
    enable = 1'b1;
    idle(3);
    tick();
    check("en_fv",  32'(frame_valid), 32'h1);
    check("en_bus", 32'(cnt_bus), 32'h0);
    check("en_win", 32'(window_id), 32'h8);
    spike_in[4] = 1'b0;
    idle(3);

    // Reset mid-window, overriding tick and spikes.
    rd_sel = 3'd0;
    pulse(0, 7);
    idle(3);
    tick();
    check("pre_bus", 32'(cnt_bus), 32'h000007);
    step();
    check("pre_rd", 32'(rd_data), 32'h7);
    pulse(0, 7);
    reset    = 1'b1;
    win_tick = 1'b1;
    spike_in = '1;
    step();
    check("mr_bus", 32'(cnt_bus), 32'h0);
    check("mr_win", 32'(window_id), 32'h0);
    check("mr_fv",  32'(frame_valid), 32'h0);
    check("mr_rd",  32'(rd_data), 32'h0);
    reset    = 1'b0;
    win_tick = 1'b0;
    spike_in = '0;
    tick();
    check("mr2_bus", 32'(cnt_bus), 32'h0);
    check("mr2_win", 32'(window_id), 32'h1);
    check("mr2_fv",  32'(frame_valid), 32'h1);

    // Window index wrap.
    win_tick = 1'b1;
    repeat (65534) step();
    check("wrap_ffff", 32'(window_id), 32'hFFFF);
    step();
    check("wrap_0", 32'(window_id), 32'h0);
    win_tick = 1'b0;
    step();
    check("wrap_fv", 32'(frame_valid), 32'h0);
    idle(3);

    // Pulse sampled two cycles before the tick.
    spike_in[5] = 1'b1;
    step();
    spike_in[5] = 1'b0;
    step();
    tick();
`ifdef SPIKE_SYNC_EN
    check("late_cur", 32'(cnt_bus), 32'h000000);
`else
    check("late_cur", 32'(cnt_bus), 32'h100000);
`endif
    idle(3);
    tick();
`ifdef SPIKE_SYNC_EN
    check("late_nxt", 32'(cnt_bus), 32'h100000);
`else
    check("late_nxt", 32'(cnt_bus), 32'h000000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
